apb_periph_node: RTL

Parametrised APB 3 peripheral interconnect node between the AHB/AXI-to-APB bridge and the SoC peripherals. It decodes each upstream transfer against NB_SLAVES inclusive address windows and forwards it through one registered stage to the selected slave. Unmapped addresses get an internal SLVERR response, and slaves that stall are aborted by an optional timeout. The first failing address is captured for software.

---
 rtl/apb_periph_node.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/apb_periph_node.sv
// APB3 interconnect node: decodes upstream transfers onto NB_SLAVES address windows through one
// registered stage, answers unmapped accesses with SLVERR and captures the first failing address.
// Define APB_NODE_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES.
module apb_periph_node #(
    parameter int unsigned NB_SLAVES      = 12,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0]           s_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]           s_pwdata_i,
    input  logic                                s_pwrite_i,
    input  logic                                s_psel_i,
    input  logic                                s_penable_i,
    output logic [APB_DATA_WIDTH-1:0]           s_prdata_o,
    output logic                                s_pready_o,
    output logic                                s_pslverr_o,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] end_addr_i,
    output logic [APB_ADDR_WIDTH-1:0]           m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]           m_pwdata_o,
    output logic                                m_pwrite_o,
    output logic [NB_SLAVES-1:0]                m_psel_o,
    output logic                                m_penable_o,
    input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0] m_prdata_i,
    input  logic [NB_SLAVES-1:0]                m_pready_i,
    input  logic [NB_SLAVES-1:0]                m_pslverr_i,
    input  logic                                err_clr_i,
    output logic                                err_valid_o,
    output logic [APB_ADDR_WIDTH-1:0]           err_addr_o,
    output logic [1:0]                          err_cause_o
);

    localparam int unsigned AW    = APB_ADDR_WIDTH;
    localparam int unsigned DW    = APB_DATA_WIDTH;
    localparam int unsigned SEL_W = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;

    localparam logic [1:0] CAUSE_MISS    = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_SLAVE   = 2'b11;

    if (NB_SLAVES < 1 || NB_SLAVES > 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("apb_periph_node: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [1:0]       cause_q;

    logic                 dec_hit;
    logic [SEL_W-1:0]     dec_idx;
    logic [NB_SLAVES-1:0] dec_onehot;
    logic                 sel_ready;
    logic                 sel_err;
    logic [DW-1:0]        sel_rdata;
    logic                 to_hit_c;

    // Window decode; descending scan so the lowest matching index is the last one written.
    always_comb begin
        dec_hit    = 1'b0;
        dec_idx    = '0;
        dec_onehot = '0;
        for (int i = NB_SLAVES - 1; i >= 0; i--) begin
            if (s_paddr_i >= start_addr_i[i*AW +: AW] && s_paddr_i <= end_addr_i[i*AW +: AW]) begin
                dec_hit         = 1'b1;
                dec_idx         = SEL_W'(i);
                dec_onehot      = '0;
                dec_onehot[i]   = 1'b1;
            end
        end
    end

    // Response mux of the currently selected slave only.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NB_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = m_pready_i[i];
                sel_err   = m_pslverr_i[i];
                sel_rdata = m_prdata_i[i*DW +: DW];
            end
        end
    end

`ifdef APB_NODE_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt_q;

    // Counts stalled ACCESS cycles; limit is hit in the TIMEOUT_CYCLES-th stalled cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            to_cnt_q <= '0;
        end else if (state_q == ACCESS && !sel_ready) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    assign to_hit_c = (state_q == ACCESS) && (to_cnt_q == TO_LAST);
`else
    assign to_hit_c = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cause_q     <= '0;
            s_prdata_o  <= '0;
            s_pready_o  <= 1'b0;
            s_pslverr_o <= 1'b0;
            m_paddr_o   <= '0;
            m_pwdata_o  <= '0;
            m_pwrite_o  <= 1'b0;
            m_psel_o    <= '0;
            m_penable_o <= 1'b0;
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
            err_cause_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_psel_i && !s_penable_i) begin
                        m_paddr_o  <= s_paddr_i;
                        m_pwdata_o <= s_pwdata_i;
                        m_pwrite_o <= s_pwrite_i;
                        sel_q      <= dec_idx;
                        if (dec_hit) begin
                            m_psel_o <= dec_onehot;
                            state_q  <= SETUP;
                        end else begin
                            s_pready_o  <= 1'b1;
                            s_pslverr_o <= 1'b1;
                            s_prdata_o  <= '0;
                            cause_q     <= CAUSE_MISS;
                            state_q     <= RESP;
                        end
                    end
                end
                SETUP: begin
                    m_penable_o <= 1'b1;
                    state_q     <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        s_prdata_o  <= sel_rdata;
                        s_pslverr_o <= sel_err;
                        s_pready_o  <= 1'b1;
                        cause_q     <= CAUSE_SLAVE;
                        m_psel_o    <= '0;
                        m_penable_o <= 1'b0;
                        state_q     <= RESP;
                    end else if (to_hit_c) begin
                        s_prdata_o  <= '0;
                        s_pslverr_o <= 1'b1;
                        s_pready_o  <= 1'b1;
                        cause_q     <= CAUSE_TIMEOUT;
                        m_psel_o    <= '0;
                        m_penable_o <= 1'b0;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    s_pready_o  <= 1'b0;
                    s_pslverr_o <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // First-error capture; a simultaneous clear takes priority.
            if (err_clr_i) begin
                err_valid_o <= 1'b0;
            end else if (state_q == RESP && s_pslverr_o && !err_valid_o) begin
                err_valid_o <= 1'b1;
                err_addr_o  <= m_paddr_o;
                err_cause_o <= cause_q;
            end
        end
    end

endmodule
